// File: rtl/crc_scan_seq_if.sv
// crc_scan_seq_if: control, memory-read and CRC-qualifier signals of the scan sequencer.
interface crc_scan_seq_if #(
    parameter int ADDR_W = 10
);
    logic              crc_start;
    logic              crc_abort;
    logic              crc_hold;
    logic [ADDR_W-1:0] start_addr;
    logic [ADDR_W-1:0] end_addr;
    logic [ADDR_W-1:0] mem_addr_out;
    logic              mem_rd_en;
    logic              crc_init;
    logic              crc_en;
    logic              crc_done;
    logic              crc_rdy;
    logic              busy;
    logic [ADDR_W:0]   word_cnt;

    modport master (
        output crc_start, crc_abort, crc_hold, start_addr, end_addr,
        input  mem_addr_out, mem_rd_en, crc_init, crc_en, crc_done, crc_rdy, busy, word_cnt
    );

    modport slave (
        input  crc_start, crc_abort, crc_hold, start_addr, end_addr,
        output mem_addr_out, mem_rd_en, crc_init, crc_en, crc_done, crc_rdy, busy, word_cnt
    );
endinterface

// File: rtl/crc_scan_seq.sv
// crc_scan_seq: streams a wrapping address range out of a synchronous memory and
// qualifies the returned words to the CRC calculator, tracking the read latency.
module crc_scan_seq #(
    parameter int ADDR_W = 10,
    parameter int RD_LAT = 2
) (
    input logic           clk50m,
    input logic           rst_n,
    crc_scan_seq_if.slave bus
);
    typedef enum logic [2:0] {IDLE, INIT, ISSUE, DRAIN, DONE} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d, mem_addr_q, mem_addr_d;
    logic [ADDR_W:0]   rem_q, rem_d, cnt_q, cnt_d;
    logic [RD_LAT-1:0] pipe_q, pipe_d;
    logic [RD_LAT:0]   flight;
    logic              rd_en_q, rd_en_d, init_q, done_q, rdy_q, busy_q;
    logic              accept, pending;

    // flight[0] is the read issued this cycle, flight[RD_LAT] the word returning now
    assign flight  = {pipe_q, rd_en_q};
    assign pending = |flight[RD_LAT-1:0];
    assign accept  = (state_q == IDLE || state_q == DONE) && bus.crc_start;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q + {{ADDR_W{1'b0}}, pipe_q[RD_LAT-1]};
        rd_en_d = 1'b0;
        if (bus.crc_abort) begin
            state_d = IDLE;
        end else if (accept) begin
            state_d = INIT;
            addr_d  = bus.start_addr;
            rem_d   = {1'b0, bus.end_addr - bus.start_addr} + 1'b1;
            cnt_d   = '0;
        end else if (state_q == INIT || state_q == ISSUE) begin
            state_d = (|rem_q) ? ISSUE : DRAIN;
            rd_en_d = (|rem_q) && !(state_q == ISSUE && bus.crc_hold);
        end else if (state_q == DRAIN && !pending) begin
            state_d = DONE;
        end
        if (rd_en_d) begin
            addr_d = addr_q + 1'b1;
            rem_d  = rem_q - 1'b1;
        end
        mem_addr_d = bus.crc_abort ? '0 : rd_en_d ? addr_q : mem_addr_q;
        pipe_d     = bus.crc_abort ? '0 : flight[RD_LAT-1:0];
    end

    always_ff @(posedge clk50m or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            rem_q      <= '0;
            cnt_q      <= '0;
            mem_addr_q <= '0;
            pipe_q     <= '0;
            rd_en_q    <= 1'b0;
            init_q     <= 1'b0;
            done_q     <= 1'b0;
            rdy_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            rem_q      <= rem_d;
            cnt_q      <= cnt_d;
            mem_addr_q <= mem_addr_d;
            pipe_q     <= pipe_d;
            rd_en_q    <= rd_en_d;
            init_q     <= state_d == INIT;
            done_q     <= state_d == DONE && state_q != DONE;
            rdy_q      <= state_d == DONE;
            busy_q     <= state_d == INIT || state_d == ISSUE || state_d == DRAIN;
        end
    end

    assign bus.mem_addr_out = mem_addr_q;
    assign bus.mem_rd_en    = rd_en_q;
    assign bus.crc_init     = init_q;
    assign bus.crc_en       = pipe_q[RD_LAT-1];
    assign bus.crc_done     = done_q;
    assign bus.crc_rdy      = rdy_q;
    assign bus.busy         = busy_q;
    assign bus.word_cnt     = cnt_q;
endmodule

// File: tb/tb_crc_scan_seq.sv
// tb_crc_scan_seq: directed scans with a cycle-stamped scoreboard of reads, crc_en,
// crc_init and crc_done events.
module tb_crc_scan_seq;
    localparam int AW  = 10;
    localparam int LAT = 2;
    localparam int NEVER = 1 << 30;

    logic clk50m = 1'b0;
    logic rst_n  = 1'b0;
    int   cyc = 0, t0 = 0, total = 0, passed = 0;
    int   q_init[$], q_rd_c[$], q_rd_a[$], q_en[$], q_done[$], q_wc[$];

    crc_scan_seq_if #(.ADDR_W(AW)) bus ();
    crc_scan_seq #(.ADDR_W(AW), .RD_LAT(LAT)) dut (.clk50m(clk50m), .rst_n(rst_n), .bus(bus));

    always #10 clk50m = ~clk50m;
    always @(posedge clk50m) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc - t0);
    endtask

    task automatic step();
        @(posedge clk50m);
        #1;
    endtask

    task automatic start(input int s, input int e);
        step();
        bus.start_addr = AW'(s);
        bus.end_addr   = AW'(e);
        bus.crc_start  = 1'b1;
        t0 = cyc;
        step();
        bus.crc_start = 1'b0;
    endtask

    task automatic go_to(input int k);
        while (cyc < t0 + k) step();
    endtask

    // expected events of a scan started at t0; reads are suppressed in cycles
    // hs+1..hs+hl (hold sampled in hs..hs+hl-1); nothing after absolute cycle cut
    task automatic push_exp(input int s, input int n, input int hs, input int hl, input int cut);
        int c = t0 + 2;
        if (t0 + 1 <= cut) q_init.push_back(t0 + 1);
        for (int i = 0; i < n; i++) begin
            while (hl > 0 && c >= t0 + hs + 1 && c <= t0 + hs + hl) c++;
            if (c <= cut) begin
                q_rd_c.push_back(c);
                q_rd_a.push_back((s + i) & ((1 << AW) - 1));
            end
            if (c + LAT <= cut) q_en.push_back(c + LAT);
            c++;
        end
        if (c + LAT <= cut) begin
            q_done.push_back(c + LAT);
            q_wc.push_back(n);
        end
    endtask

    task automatic wait_rdy(input string name, input int exp_rel);
        int k = 0;
        while (!bus.crc_rdy && k < 2000) begin
            step();
            k++;
        end
        check(name, cyc - t0, exp_rel);
    endtask

    task automatic check_zero(input string name);
        check({name, "_addr"}, int'(bus.mem_addr_out), 0);
        check({name, "_rd_en"}, int'(bus.mem_rd_en), 0);
        check({name, "_crc_en"}, int'(bus.crc_en), 0);
        check({name, "_init"}, int'(bus.crc_init), 0);
        check({name, "_done"}, int'(bus.crc_done), 0);
        check({name, "_rdy"}, int'(bus.crc_rdy), 0);
        check({name, "_busy"}, int'(bus.busy), 0);
        check({name, "_wcnt"}, int'(bus.word_cnt), 0);
    endtask

    always @(negedge clk50m) begin
        int ec, ea;
        if (rst_n) begin
            if (bus.crc_init) begin
                ec = -1;
                if (q_init.size() > 0) ec = q_init.pop_front();
                check("init_cycle", cyc, ec);
            end
            if (bus.mem_rd_en) begin
                ec = -1;
                ea = -1;
                if (q_rd_c.size() > 0) begin
                    ec = q_rd_c.pop_front();
                    ea = q_rd_a.pop_front();
                end
                check("rd_cycle", cyc, ec);
                check("rd_addr", int'(bus.mem_addr_out), ea);
            end
            if (bus.crc_en) begin
                ec = -1;
                if (q_en.size() > 0) ec = q_en.pop_front();
                check("crc_en_cycle", cyc, ec);
            end
            if (bus.crc_done) begin
                ec = -1;
                ea = -1;
                if (q_done.size() > 0) begin
                    ec = q_done.pop_front();
                    ea = q_wc.pop_front();
                end
                check("done_cycle", cyc, ec);
                check("done_wcnt", int'(bus.word_cnt), ea);
                check("done_rdy", int'(bus.crc_rdy), 1);
                check("done_busy", int'(bus.busy), 0);
            end
        end
    end

    initial begin
        bus.crc_start  = 1'b0;
        bus.crc_abort  = 1'b0;
        bus.crc_hold   = 1'b0;
        bus.start_addr = '0;
        bus.end_addr   = '0;
        repeat (3) step();
        check_zero("reset");
        rst_n = 1'b1;
        step();

        // full range 0..1023
        start(0, 1023);
        push_exp(0, 1024, 0, 0, NEVER);
        wait_rdy("full_done_cycle", 1028);
        check("full_wcnt", int'(bus.word_cnt), 1024);

        // wrap through 0
        start(1020, 3);
        push_exp(1020, 8, 0, 0, NEVER);
        wait_rdy("wrap_done_cycle", 12);
        check("wrap_wcnt", int'(bus.word_cnt), 8);

        // single word
        start(5, 5);
        push_exp(5, 1, 0, 0, NEVER);
        wait_rdy("single_done_cycle", 5);
        check("single_wcnt", int'(bus.word_cnt), 1);

        // hold for 3 cycles, plus a start pulse while busy that must be ignored
        start(100, 115);
        push_exp(100, 16, 6, 3, NEVER);
        go_to(6);
        bus.crc_hold = 1'b1;
        go_to(9);
        bus.crc_hold = 1'b0;
        go_to(10);
        bus.start_addr = AW'(500);
        bus.end_addr   = AW'(600);
        bus.crc_start  = 1'b1;
        step();
        bus.crc_start = 1'b0;
        wait_rdy("hold_done_cycle", 23);
        check("hold_wcnt", int'(bus.word_cnt), 16);

        // abort in cycle 100 of a full scan
        start(0, 1023);
        push_exp(0, 1024, 0, 0, t0 + 100);
        go_to(100);
        bus.crc_abort = 1'b1;
        step();
        bus.crc_abort = 1'b0;
        check("abort_busy", int'(bus.busy), 0);
        check("abort_rdy", int'(bus.crc_rdy), 0);
        check("abort_addr", int'(bus.mem_addr_out), 0);
        check("abort_rd_en", int'(bus.mem_rd_en), 0);
        check("abort_crc_en", int'(bus.crc_en), 0);
        check("abort_wcnt", int'(bus.word_cnt), 97);
        repeat (5) step();
        check("abort_idle_rdy", int'(bus.crc_rdy), 0);

        // fresh scan after abort
        start(10, 12);
        push_exp(10, 3, 0, 0, NEVER);
        wait_rdy("post_abort_done_cycle", 7);
        check("post_abort_wcnt", int'(bus.word_cnt), 3);

        // asynchronous reset mid-scan
        start(0, 1023);
        push_exp(0, 1024, 0, 0, t0 + 49);
        go_to(50);
        rst_n = 1'b0;
        #1;
        check_zero("midreset");
        step();
        step();
        rst_n = 1'b1;

        // scan, linger in DONE, then restart from DONE across the wrap
        start(7, 7);
        push_exp(7, 1, 0, 0, NEVER);
        wait_rdy("after_reset_done_cycle", 5);
        repeat (3) step();
        check("done_level_rdy", int'(bus.crc_rdy), 1);
        start(1022, 1);
        push_exp(1022, 4, 0, 0, NEVER);
        check("restart_rdy_drop", int'(bus.crc_rdy), 0);
        check("restart_busy", int'(bus.busy), 1);
        wait_rdy("restart_done_cycle", 8);
        check("restart_wcnt", int'(bus.word_cnt), 4);

        repeat (4) step();
        check("scoreboard_empty", q_init.size() + q_rd_c.size() + q_en.size() + q_done.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/crc_scan_seq.md
# crc_scan_seq

Parametrised memory-scan sequencer for the CRC check path; successor to the fixed 1024-word CRC FSM. On `crc_start` it streams an address range (with wrap-around) out of a synchronous memory at one read per cycle. It tracks a configurable memory read latency and qualifies each returned word to the CRC calculator with `crc_en`. It sits between the control interface and the memory / CRC-calc / CRC-compare blocks, and adds init, hold, abort, word count and completion signalling.

## Interface
- `ADDR_W`, 10, memory address width
- `RD_LAT`, 2, memory read latency in cycles from `mem_rd_en` to valid data; legal range 1..4
- `clk50m`  in  1  system clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `crc_start`  in  1  start scan; sampled only in IDLE or DONE
- `crc_abort`  in  1  cancel scan; sampled in every state
- `crc_hold`  in  1  stall address issue while high
- `start_addr`  in  ADDR_W  first address; latched when the start is accepted
- `end_addr`  in  ADDR_W  last address (inclusive); latched when the start is accepted
- `mem_addr_out`  out  ADDR_W  memory read address
- `mem_rd_en`  out  1  memory read strobe
- `crc_init`  out  1  one-cycle pulse; clears the CRC accumulator
- `crc_en`  out  1  memory data valid this cycle; enables crc_calc
- `crc_done`  out  1  one-cycle pulse on scan completion
- `crc_rdy`  out  1  level; scan complete, result valid for compare
- `busy`  out  1  high in INIT, ISSUE and DRAIN
- `word_cnt`  out  ADDR_W+1  number of `crc_en` cycles in the current or last scan

## Operation
- States: IDLE, INIT, ISSUE, DRAIN, DONE.
- **IDLE / DONE → INIT** on `crc_start`. On the accepting edge:
  - latch `start_addr`/`end_addr`;
  - load remaining = ((end − start) mod 2^ADDR_W) + 1, held in an ADDR_W+1 bit counter;
  - clear `word_cnt`.
- **INIT:** `crc_init`=1 for one cycle; next state ISSUE.
- **ISSUE:**
  - If `crc_hold`=0: `mem_rd_en`=1, `mem_addr_out` = current address. Address then increments modulo 2^ADDR_W (1023 → 0 at ADDR_W=10) and remaining decrements.
  - If `crc_hold`=1: `mem_rd_en`=0, address frozen.
  - Leave for DRAIN after the issue that brings remaining to 0.
- **Valid pipeline:** RD_LAT-stage shift register of `mem_rd_en`. Its output is `crc_en`. `word_cnt` increments on each `crc_en`.
- **DRAIN:** no issues. Move to DONE the cycle after the pipeline empties, i.e. after the last `crc_en`.
- **DONE:** `crc_rdy`=1 as a level; `crc_done`=1 on the entry cycle only. Stay in DONE until `crc_start` or `crc_abort`. `crc_start` in DONE immediately begins a new scan and drops `crc_rdy`.
- **Abort:** `crc_abort`=1 in any state → IDLE at the next edge.
  - Valid pipeline is cleared, so no `crc_en` occurs after that edge.
  - `crc_rdy` and `crc_done` are not asserted; `word_cnt` keeps its value.
- **Start and abort in the same cycle:** abort wins → IDLE.
- **Start while busy:** ignored. `start_addr`/`end_addr` changes while busy have no effect.
- **Range:**
  - `start_addr` = `end_addr` → exactly 1 word.
  - `end_addr` = `start_addr` − 1 (mod) → full 2^ADDR_W words.
  - `start_addr` > `end_addr` → wraps through 0.
- **`mem_addr_out`:**
  - Holds its last value outside ISSUE.
  - Reset and abort set it to 0.

## Timing
- **Reset:** all outputs 0, state IDLE, pipeline empty, `word_cnt`=0.
- **Cycle numbering:** cycle 0 is the cycle in which `crc_start` is sampled high.
  - cycle 1: INIT, `crc_init`=1, `busy`=1;
  - cycles 2 .. N+1: reads of `start_addr` .. `end_addr` (no hold);
  - `crc_en` in cycles 2+RD_LAT .. N+1+RD_LAT;
  - `crc_done`/`crc_rdy` rise in cycle N+2+RD_LAT, and `busy` falls in the same cycle.
- **Hold:** each hold cycle during ISSUE delays all later events by 1 cycle. Hold has no effect in other states, and in-flight reads still return.
- **Back-to-back scans:** restart from DONE takes 1 INIT cycle. There is no dead cycle beyond INIT.
- **Registered outputs:** all outputs are registered, with no combinational path from input to output.

## Test plan
- **Full scan:** reset, then `start_addr`=0, `end_addr`=1023, RD_LAT=2, pulse `crc_start` → `crc_init` in cycle 1, addresses 0..1023 in cycles 2..1025, `crc_en` in cycles 4..1027, `crc_done` pulse and `crc_rdy`=1 in cycle 1028, `word_cnt`=1024.
- **Wrap-around:** `start_addr`=1020, `end_addr`=3 → 8 reads at 1020, 1021, 1022, 1023, 0, 1, 2, 3; `word_cnt`=8; `crc_done` in cycle 12.
- **Single word:** `start_addr`=`end_addr`=5 → one `mem_rd_en` at address 5 in cycle 2; `crc_en` in cycle 4; `crc_done` in cycle 5.
- **Hold:** 16-word scan with `crc_hold`=1 for 3 cycles starting cycle 6 → no `mem_rd_en` during the hold, address sequence unbroken, `crc_done` 3 cycles later (cycle 23); a `crc_start` pulse while busy is ignored.
- **Abort:** `crc_abort` in cycle 100 of a full scan → IDLE at cycle 101, no `crc_en` from cycle 101 on, `crc_rdy`=0, `busy`=0, `mem_addr_out`=0; a fresh start then completes normally.
- **Reset mid-scan and restart from DONE:** `rst_n` low mid-scan → all outputs 0 immediately. A `crc_start` while in DONE → `crc_rdy` falls next cycle, `crc_init` pulses, and the new scan completes.
